fdiv_ratio_ctrl: RTL and testbench

//  Sequencer that reprograms the 8-bit ratio n of the 50%-duty clock divider at run time.

---
 rtl/fdiv_ratio_ctrl.sv | 133 +++++++++++++
 tb/tb_fdiv_ratio_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_ratio_ctrl.sv
// Run-time ratio sequencer for the 50%-duty clock divider: accepts a new ratio, waits for the
// divider low phase, then holds the divider in reset while n changes. Option: FDIV_RATIO_CTRL_CLAMP_EN.
module fdiv_ratio_ctrl #(
    parameter logic [7:0]  RST_N    = 8'd2,
    parameter int unsigned HOLD_CYC = 4,
    parameter int unsigned DRAIN_TO = 511
) (
    input  logic       i_clk_in,
    input  logic       i_rst,
    input  logic       i_req_valid,
    input  logic [7:0] i_req_n,
    output logic       o_req_ready,
    input  logic       i_div_clk,
    output logic [7:0] o_div_n,
    output logic       o_div_rst_n,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic       o_drain_to
);

    typedef enum logic [1:0] {StIdle, StDrain, StHold, StRelease} state_t;

    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
    localparam logic [8:0] DRAIN_LAST = 9'(DRAIN_TO - 1);

    state_t     r_state;
    logic [7:0] r_hold_cnt;
    logic [8:0] r_to_cnt;
    logic [7:0] r_pend_n;
    logic [7:0] r_div_n;
    logic       r_div_rst_n;
    logic       r_req_ready;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic       r_drain_to;
    logic       r_boot;
    logic [1:0] r_sync;

    logic       w_fire;
    logic       w_req_low;
    logic [7:0] w_req_n;
    logic       w_div_clk_s;

`ifdef FDIV_RATIO_CTRL_CLAMP_EN
    assign w_req_low = 1'b0;
    assign w_req_n   = (i_req_n < 8'd2) ? 8'd2 : i_req_n;
`else
    assign w_req_low = (i_req_n < 8'd2);
    assign w_req_n   = i_req_n;
`endif

    assign w_fire      = i_req_valid & r_req_ready;
    assign w_div_clk_s = r_sync[1];

    always_ff @(posedge i_clk_in or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StHold;
            r_hold_cnt  <= 8'd0;
            r_to_cnt    <= 9'd0;
            r_pend_n    <= RST_N;
            r_div_n     <= RST_N;
            r_div_rst_n <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_drain_to  <= 1'b0;
            r_boot      <= 1'b1;
            r_sync      <= 2'b00;
        end else begin
            r_sync     <= {r_sync[0], i_div_clk};
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_drain_to <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_fire) begin
                        if (w_req_low) begin
                            r_err <= 1'b1;
                        end else if (w_req_n == r_div_n) begin
                            r_done <= 1'b1;
                        end else begin
                            r_pend_n    <= w_req_n;
                            r_to_cnt    <= 9'd0;
                            r_req_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // Low phase seen, or give up waiting and force the switch
                    if (!w_div_clk_s || (r_to_cnt == DRAIN_LAST)) begin
                        r_drain_to  <= w_div_clk_s;
                        r_div_rst_n <= 1'b0;
                        r_div_n     <= r_pend_n;
                        r_hold_cnt  <= 8'd0;
                        r_state     <= StHold;
                    end else begin
                        r_to_cnt <= r_to_cnt + 9'd1;
                    end
                end
                StHold: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_div_rst_n <= 1'b1;
                        r_done      <= ~r_boot;
                        r_boot      <= 1'b0;
                        r_state     <= StRelease;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                StRelease: begin
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_div_n     = r_div_n;
    assign o_div_rst_n = r_div_rst_n;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_drain_to  = r_drain_to;

endmodule

// File: tb/tb_fdiv_ratio_ctrl.sv
// Scoreboard bench for fdiv_ratio_ctrl: randomized ratio requests against a ratio-level model.
module tb_fdiv_ratio_ctrl;

    localparam int         HOLD_CYC = 4;
    localparam int         DRAIN_TO = 511;
    localparam logic [7:0] RST_N    = 8'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_n = 8'd0;
    logic       div_clk = 1'b0;
    logic       req_ready;
    logic [7:0] div_n;
    logic       div_rst_n;
    logic       busy;
    logic       done;
    logic       err;
    logic       drain_to;

    fdiv_ratio_ctrl #(
        .RST_N    (RST_N),
        .HOLD_CYC (HOLD_CYC),
        .DRAIN_TO (DRAIN_TO)
    ) dut (
        .i_clk_in    (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_n     (req_n),
        .o_req_ready (req_ready),
        .i_div_clk   (div_clk),
        .o_div_n     (div_n),
        .o_div_rst_n (div_rst_n),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_drain_to  (drain_to)
    );

    always #5 clk = ~clk;

    // kind: 0 = done, 1 = err, 2 = drain_to; n = div_n expected while the pulse is high
    typedef struct {
        int kind;
        int n;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cur_n = 2;
    int   dclk_mode = 0;

    function automatic void chk(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // div_clk: 0 = held low, 1 = toggling with random half-period, 2 = held high
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (dclk_mode == 0) div_clk = 1'b0;
            else if (dclk_mode == 2) div_clk = 1'b1;
            else if (cnt == 0) begin
                div_clk = ~div_clk;
                cnt = $urandom_range(1, 6);
            end else cnt--;
        end
    end

    // Monitor: pops and compares whenever a result pulse appears
    initial begin
        int   prev_n;
        int   np;
        int   k;
        exp_t e;
        prev_n = RST_N;
        forever begin
            @(negedge clk);
            if (!rst) begin
                np = int'(done) + int'(err) + int'(drain_to);
                if (np > 1) chk(1'b0, "pulse_exclusive", np, 1);
                if (np == 1) begin
                    k = done ? 0 : (err ? 1 : 2);
                    if (sb.size() == 0) begin
                        chk(1'b0, "unexpected_pulse_kind", k, -1);
                    end else begin
                        e = sb.pop_front();
                        chk(e.kind == k, "pulse_kind", k, e.kind);
                        chk(e.n == int'(div_n), "pulse_div_n", int'(div_n), e.n);
                    end
                end
                if (int'(div_n) != prev_n) chk(div_rst_n == 1'b0, "div_n_change_in_reset",
                                               int'(div_rst_n), 0);
            end
            prev_n = int'(div_n);
        end
    end

    task automatic boot_check();
        int lo;
        bit got;
        @(negedge clk);
        rst = 1'b0;
        lo = 0;
        got = 1'b0;
        while (!got && lo < 100) begin
            if (div_rst_n) got = 1'b1;
            else begin
                lo++;
                @(negedge clk);
            end
        end
        chk(lo == HOLD_CYC, "boot_hold_len", lo, HOLD_CYC);
        chk(done == 1'b0, "boot_no_done", int'(done), 0);
        @(negedge clk);
        chk(req_ready == 1'b1, "boot_req_ready", int'(req_ready), 1);
        chk(busy == 1'b0, "boot_busy", int'(busy), 0);
        chk(int'(div_n) == int'(RST_N), "boot_div_n", int'(div_n), int'(RST_N));
    endtask

    task automatic reset_values();
        chk(div_rst_n == 1'b0, "rst_div_rst_n", int'(div_rst_n), 0);
        chk(int'(div_n) == int'(RST_N), "rst_div_n", int'(div_n), int'(RST_N));
        chk(req_ready == 1'b0, "rst_req_ready", int'(req_ready), 0);
        chk(busy == 1'b1, "rst_busy", int'(busy), 1);
        chk({done, err, drain_to} == 3'b000, "rst_pulses", int'({done, err, drain_to}), 0);
    endtask

    task automatic issue(input int n, input int mode);
        int lat;
        int lo;
        int dto_lat;
        int eff;
        bit low;
        bit got;
        bit sw;
        dclk_mode = mode;
        repeat (4) @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_n = 8'(n);
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        chk(got, "req_ready_wait", int'(got), 1);
        if (!got) begin
            req_valid = 1'b0;
            return;
        end
`ifdef FDIV_RATIO_CTRL_CLAMP_EN
        eff = (n < 2) ? 2 : n;
        low = 1'b0;
`else
        eff = n;
        low = (n < 2);
`endif
        sw = 1'b0;
        if (low) sb.push_back('{1, cur_n});
        else if (eff == cur_n) sb.push_back('{0, cur_n});
        else begin
            sw = 1'b1;
            if (mode == 2) sb.push_back('{2, eff});
            sb.push_back('{0, eff});
            cur_n = eff;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_n = 8'($urandom);
        lat = 1;
        lo = 0;
        dto_lat = 0;
        got = 1'b0;
        while (!got && lat <= 2000) begin
            @(negedge clk);
            if (!div_rst_n) lo++;
            if (drain_to) dto_lat = lat;
            if (done || err) got = 1'b1;
            else lat++;
        end
        chk(got, "completion_wait", int'(got), 1);
        if (!sw) begin
            chk(lat == 1, "noop_latency", lat, 1);
            chk(busy == 1'b0, "noop_busy", int'(busy), 0);
            chk(lo == 0, "noop_no_reset", lo, 0);
        end else begin
            chk(lo == HOLD_CYC, "hold_len", lo, HOLD_CYC);
            chk(div_rst_n == 1'b1, "release_with_done", int'(div_rst_n), 1);
            if (mode == 0) chk(lat == HOLD_CYC + 2, "switch_latency", lat, HOLD_CYC + 2);
            if (mode == 2) begin
                chk(dto_lat == DRAIN_TO + 1, "drain_to_latency", dto_lat, DRAIN_TO + 1);
                chk(lat == DRAIN_TO + HOLD_CYC + 1, "forced_latency", lat,
                    DRAIN_TO + HOLD_CYC + 1);
            end
        end
        chk(int'(div_n) == cur_n, "div_n_after", int'(div_n), cur_n);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int r;
        int mode;
        bit got;
        // Boot sequence
        #1;
        rst = 1'b1;
        sb.delete();
        cur_n = RST_N;
        @(posedge clk);
        #1;
        reset_values();
        boot_check();

        issue(5, 0);
        issue(1, 0);
        issue(7, 2);
        issue(cur_n, 0);

        // Reset in HOLD with 9 pending: aborted request must produce nothing
        dclk_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_n = 8'd9;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        chk(got, "abort_req_ready", int'(got), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(div_rst_n == 1'b0 && div_n == 8'd9, "abort_in_hold", int'(div_n), 9);
        rst = 1'b1;
        sb.delete();
        cur_n = RST_N;
        #1;
        reset_values();
        boot_check();

        for (int t = 0; t < 30; t++) begin
            r = $urandom_range(0, 5);
            if (r == 0) n = $urandom_range(0, 1);
            else if (r == 1) n = cur_n;
            else n = $urandom_range(2, 255);
            r = $urandom_range(0, 9);
            mode = (r == 0) ? 2 : ((r < 4) ? 1 : 0);
            issue(n, mode);
        end

        repeat (4) @(negedge clk);
        chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
